spi_master_multi: RTL

//  Parametrised SPI master for the avionics sensor bus; successor to the fixed single-slave master.

---
 rtl/spi_master_multi.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/spi_master_multi.sv
// spi_master_multi: SPI master with DATA_W-bit MSB-first words, NUM_SS active-low selects and runtime CPOL/CPHA.
// Define SPI_MASTER_MULTI_BURST_EN to add HOLD_SS, which keeps SS asserted between back-to-back words.
module spi_master_multi #(
  parameter int DATA_W  = 8,
  parameter int NUM_SS  = 4,
  parameter int CLK_DIV = 13,
  localparam int SEL_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [SEL_W-1:0]  SS_SEL,
  input  logic [1:0]        MODE,
  input  logic [DATA_W-1:0] TX_DATA,
`ifdef SPI_MASTER_MULTI_BURST_EN
  input  logic              HOLD_SS,
`endif
  output logic [DATA_W-1:0] RX_DATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              SCK,
  output logic              MOSI,
  input  logic              MISO,
  output logic [NUM_SS-1:0] SS
);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int CNT_W = $clog2(2 * DATA_W);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, WAIT} state_t;

  state_t            state;
  logic [DIV_W-1:0]  div;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic              cpol;
  logic              cpha;
  logic              tick;
  logic              lead;
  logic              sample;
  logic              last_edge;

  assign tick      = (div == DIV_W'(CLK_DIV - 1));
  assign lead      = ~cnt[0];
  assign sample    = lead ^ cpha;
  assign last_edge = (cnt == CNT_W'(2 * DATA_W - 1));

  // Out-of-range indices leave every select deasserted.
  function automatic logic [NUM_SS-1:0] ss_mask(input logic [SEL_W-1:0] idx);
    logic [NUM_SS-1:0] m;
    m = '1;
    for (int i = 0; i < NUM_SS; i++)
      if (32'(idx) == i) m[i] = 1'b0;
    return m;
  endfunction

  // With CPHA=0 the MSB goes out at START, so the shifter is preloaded one bit ahead.
  function automatic logic [DATA_W-1:0] tx_load(input logic [DATA_W-1:0] tx, input logic pha);
    return pha ? tx : {tx[DATA_W-2:0], 1'b0};
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      div     <= '0;
      cnt     <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      cpol    <= 1'b0;
      cpha    <= 1'b0;
      SCK     <= 1'b0;
      MOSI    <= 1'b0;
      SS      <= '1;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      RX_DATA <= '0;
    end else begin
      DONE <= 1'b0;
      div  <= (state == IDLE || state == WAIT || tick) ? '0 : div + DIV_W'(1);
      case (state)
        IDLE: begin
          SCK <= cpol;
          if (START && !DONE) begin
            cpol  <= MODE[1];
            cpha  <= MODE[0];
            SCK   <= MODE[1];
            SS    <= ss_mask(SS_SEL);
            BUSY  <= 1'b1;
            tx_sr <= tx_load(TX_DATA, MODE[0]);
            if (!MODE[0]) MOSI <= TX_DATA[DATA_W-1];
            state <= SETUP;
          end
        end
        SETUP: begin
          if (tick) begin
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            SCK <= ~SCK;
            cnt <= cnt + CNT_W'(1);
            if (sample) begin
              rx_sr <= {rx_sr[DATA_W-2:0], MISO};
            end else if (!last_edge) begin
              MOSI  <= tx_sr[DATA_W-1];
              tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
            end
            if (last_edge) state <= HOLD;
          end
        end
        HOLD: begin
          if (tick) begin
            DONE    <= 1'b1;
            RX_DATA <= rx_sr;
            BUSY    <= 1'b0;
`ifdef SPI_MASTER_MULTI_BURST_EN
            if (HOLD_SS) begin
              state <= WAIT;
            end else begin
              SS    <= '1;
              state <= IDLE;
            end
`else
            SS    <= '1;
            state <= IDLE;
`endif
          end
        end
        WAIT: begin
          // Select stays asserted; the next word reuses the latched mode and skips SETUP.
          SCK <= cpol;
          if (START && !DONE) begin
            BUSY  <= 1'b1;
            cnt   <= '0;
            tx_sr <= tx_load(TX_DATA, cpha);
            if (!cpha) MOSI <= TX_DATA[DATA_W-1];
            state <= SHIFT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
